// File: rtl/bit_packer_fifo.sv
// bit_packer_fifo: compacts valid input lanes LSB-first into OUT_W-bit words queued in a DEPTH-entry FIFO
module bit_packer_fifo #(
  parameter int IN_LANES = 6,
  parameter int OUT_W    = 16,
  parameter int DEPTH    = 4,
  parameter int CNT_W    = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [IN_LANES-1:0]          in_valid,
  input  logic [IN_LANES-1:0]          in_bits,
  input  logic                         flush,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [OUT_W-1:0]             out_data,
  output logic [$clog2(DEPTH+1)-1:0]   fill_level,
  output logic [$clog2(OUT_W)-1:0]     acc_level,
  output logic [CNT_W-1:0]             drop_count,
  output logic                         overflow
);
  localparam int FW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(OUT_W);
  localparam int KW = $clog2(IN_LANES + 1);
  localparam int SW = AW + 2;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int EW = OUT_W + IN_LANES;

  logic [OUT_W-1:0]    r_acc;
  logic [AW-1:0]       r_acc_level;
  logic [OUT_W-1:0]    r_mem [DEPTH];
  logic [PW-1:0]       r_rd, r_wr;
  logic [FW-1:0]       r_fill;
  logic [CNT_W-1:0]    r_drop;
  logic                r_ovf;
  logic [IN_LANES-1:0] w_comp;
  logic [KW-1:0]       w_k;
  logic [SW-1:0]       w_sum;
  logic [EW-1:0]       w_ext;
  logic                w_done, w_pop, w_full, w_push, w_drop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // gather valid lanes in ascending order into a dense low-aligned vector
  always_comb begin
    w_comp = '0;
    w_k    = '0;
    for (int i = 0; i < IN_LANES; i++)
      if (in_valid[i]) begin
        w_comp[w_k] = in_bits[i];
        w_k         = w_k + 1'b1;
      end
  end

  // accumulator bits above acc_level are always zero, so appending is a shifted OR
  assign w_sum    = SW'(r_acc_level) + SW'(w_k);
  assign w_ext    = EW'(r_acc) | (EW'(w_comp) << r_acc_level);
  assign w_done   = !flush && (w_sum >= SW'(OUT_W));
  assign w_pop    = out_valid && out_ready;
  assign w_full   = r_fill == FW'(DEPTH);
  assign w_push   = w_done && (!w_full || w_pop);
  assign w_drop   = w_done && w_full && !w_pop;

  assign out_valid  = r_fill != '0;
  assign out_data   = out_valid ? r_mem[r_rd] : '0;
  assign fill_level = r_fill;
  assign acc_level  = r_acc_level;
  assign drop_count = r_drop;
  assign overflow   = r_ovf;

  // accumulator: flush clears, completion keeps only the spill-over bits
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_acc       <= '0;
      r_acc_level <= '0;
    end else if (w_done) begin
      r_acc       <= OUT_W'(w_ext >> OUT_W);
      r_acc_level <= AW'(w_sum - SW'(OUT_W));
    end else begin
      r_acc       <= w_ext[OUT_W-1:0];
      r_acc_level <= AW'(w_sum);
    end
  end

  // word storage; contents need no reset because fill gates visibility
  always_ff @(posedge clk) begin
    if (!reset && w_push) r_mem[r_wr] <= w_ext[OUT_W-1:0];
  end

  // FIFO pointers, occupancy and overflow accounting
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd   <= '0;
      r_wr   <= '0;
      r_fill <= '0;
      r_drop <= '0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_push) r_wr <= nxt(r_wr);
      if (w_pop) r_rd <= nxt(r_rd);
      r_fill <= r_fill + FW'(w_push) - FW'(w_pop);
      if (w_drop) begin
        r_ovf <= 1'b1;
        if (~&r_drop) r_drop <= r_drop + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_bit_packer_fifo.sv
// tb_bit_packer_fifo: directed self-checking bench for bit_packer_fifo
module tb_bit_packer_fifo;
  logic        clk = 0;
  logic        reset, flush, out_ready, out_valid, overflow;
  logic [5:0]  in_valid, in_bits;
  logic [15:0] out_data, drop_count;
  logic [2:0]  fill_level;
  logic [3:0]  acc_level;
  int          n_chk = 0;
  int          n_fail = 0;

  bit_packer_fifo dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_bits(in_bits), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .fill_level(fill_level), .acc_level(acc_level), .drop_count(drop_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step(input logic [5:0] v, input logic [5:0] b);
    in_valid = v;
    in_bits  = b;
    @(posedge clk);
    #1;
    in_valid = '0;
    in_bits  = '0;
    flush    = 1'b0;
  endtask

  task automatic push_word(input logic [15:0] w);
    step(6'h3F, w[5:0]);
    step(6'h3F, w[11:6]);
    step(6'h0F, {2'b00, w[15:12]});
  endtask

  initial begin
    reset = 1; flush = 0; out_ready = 0; in_valid = 6'h3F; in_bits = 6'h3F;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_fill", fill_level, 0);
    chk("rst_acc", acc_level, 0);
    chk("rst_drop", drop_count, 0);
    chk("rst_ovf", overflow, 0);
    reset = 0; in_valid = 0; in_bits = 0;
    step(6'b101001, 6'b100001);
    chk("cmp_acc", acc_level, 3);
    chk("cmp_valid", out_valid, 0);
    step(6'h3F, 0); step(6'h3F, 0); step(6'b000001, 0);
    chk("cmp_word", out_data, 16'h0005);
    chk("cmp_acc0", acc_level, 0);
    chk("cmp_fill", fill_level, 1);
    out_ready = 1; step(0, 0); out_ready = 0;
    chk("cmp_empty", out_valid, 0);
    chk("cmp_data0", out_data, 0);
    step(6'h3F, 6'b000001); step(6'h3F, 0); step(6'h3F, 6'b110000);
    chk("wc_valid", out_valid, 1);
    chk("wc_data", out_data, 16'h0001);
    chk("wc_acc", acc_level, 2);
    chk("wc_fill", fill_level, 1);
    step(6'h3F, 0); step(6'h3F, 0); step(6'b000011, 0);
    chk("wc_fill2", fill_level, 2);
    chk("wc_acc2", acc_level, 0);
    out_ready = 1; step(0, 0);
    chk("wc_word2", out_data, 16'h0003);
    step(0, 0); out_ready = 0;
    chk("wc_empty", fill_level, 0);
    for (int i = 1; i <= 5; i++) push_word(16'(i));
    chk("ov_fill", fill_level, 4);
    chk("ov_drop", drop_count, 1);
    chk("ov_flag", overflow, 1);
    chk("ov_head", out_data, 16'h0001);
    out_ready = 1;
    for (int i = 1; i <= 4; i++) begin
      chk("ov_pop", out_data, 32'(i));
      step(0, 0);
    end
    out_ready = 0;
    chk("ov_empty", out_valid, 0);
    for (int i = 0; i < 4; i++) push_word(16'h0011 + 16'(i));
    chk("pp_full", fill_level, 4);
    step(6'h3F, 6'h15); step(6'h3F, 0);
    out_ready = 1; step(6'h0F, 0); out_ready = 0;
    chk("pp_fill", fill_level, 4);
    chk("pp_drop", drop_count, 1);
    chk("pp_head", out_data, 16'h0012);
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      chk("pp_pop", out_data, 32'h12 + 32'(i));
      step(0, 0);
    end
    out_ready = 0;
    chk("pp_empty", fill_level, 0);
    step(6'h3F, 6'h3F); step(6'h0F, 6'h0F);
    chk("fl_pre", acc_level, 10);
    flush = 1; step(6'h3F, 6'h3F);
    chk("fl_acc", acc_level, 0);
    chk("fl_nopush", fill_level, 0);
    push_word(16'hA5C3);
    chk("fl_word", out_data, 16'hA5C3);
    chk("fl_acc2", acc_level, 0);
    chk("fl_drop", drop_count, 1);
    chk("fl_ovf", overflow, 1);
    push_word(16'h1234); push_word(16'h5678); step(6'h3F, 6'h2A);
    chk("rm_fill", fill_level, 3);
    chk("rm_acc", acc_level, 6);
    reset = 1; @(posedge clk); #1; reset = 0;
    chk("rm_valid", out_valid, 0);
    chk("rm_fill0", fill_level, 0);
    chk("rm_acc0", acc_level, 0);
    chk("rm_drop", drop_count, 0);
    chk("rm_ovf", overflow, 0);
    chk("rm_data", out_data, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
